// File: rtl/psoc_audio_pkg.sv
// Shared audio-path constants and types, used by the I2S capture and playback blocks
// and by the register file.
package psoc_audio_pkg;

    localparam int unsigned SAMPLE_BITS_DEFAULT = 24;

    typedef enum logic {
        StWaitSync = 1'b0,
        StCapture  = 1'b1
    } rx_state_e;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_if.sv
// Stereo frame stream between the I2S receiver and the capture FIFO.
interface i2s_rx_if #(
    parameter int unsigned SAMPLE_BITS = psoc_audio_pkg::SAMPLE_BITS_DEFAULT
);
    logic [2*SAMPLE_BITS-1:0] sample_data;
    logic                     sample_valid;
    logic                     sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_rx_sync.sv
// Synchronizes the three asynchronous I2S pins into clk and flags rising SCLK edges.
module i2s_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i2s_sclk,
    input  logic i2s_lrclk,
    input  logic i2s_sdata,
    output logic sclk_rise,
    output logic lrclk_s,
    output logic sdata_s
);
    logic [SYNC_STAGES-1:0] sclk_q, sclk_d, lr_q, lr_d, sd_q, sd_d;
    logic                   sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_d      = {sclk_q[SYNC_STAGES-2:0], i2s_sclk};
        lr_d        = {lr_q[SYNC_STAGES-2:0], i2s_lrclk};
        sd_d        = {sd_q[SYNC_STAGES-2:0], i2s_sdata};
        sclk_prev_d = sclk_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= '0;
            lr_q        <= '0;
            sd_q        <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            lr_q        <= lr_d;
            sd_q        <= sd_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign lrclk_s   = lr_q[SYNC_STAGES-1];
    assign sdata_s   = sd_q[SYNC_STAGES-1];
endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: deserializes left/right words and emits {left,right} frames on a stream.
// Optional peak meters are built when I2S_RX_PEAK_EN is defined.
module i2s_rx
    import psoc_audio_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             i2s_sclk,
    input  logic             i2s_lrclk,
    input  logic             i2s_sdata,
    i2s_rx_if.master         out_if,
    output logic             overflow,
    input  logic             ovf_clr
`ifdef I2S_RX_PEAK_EN
    ,
    output logic [SAMPLE_BITS-1:0] peak_l,
    output logic [SAMPLE_BITS-1:0] peak_r,
    input  logic                   peak_clr
`endif
);
    localparam int unsigned CntW = $clog2(SAMPLE_BITS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_BITS);

    logic sclk_rise, lrclk_s, sdata_s;

    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i2s_sclk (i2s_sclk),
        .i2s_lrclk(i2s_lrclk),
        .i2s_sdata(i2s_sdata),
        .sclk_rise(sclk_rise),
        .lrclk_s  (lrclk_s),
        .sdata_s  (sdata_s)
    );

    rx_state_e                state_q, state_d;
    logic                     lr_prev_q, lr_prev_d, lr_seen_q, lr_seen_d;
    logic [CntW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_BITS-1:0]   word_q, word_d, left_q, left_d, word_ins, msb_bit;
    logic                     left_ok_q, left_ok_d;
    logic [2*SAMPLE_BITS-1:0] data_q, data_d;
    logic                     valid_q, valid_d, ovf_q, ovf_d;
    logic                     boundary, word_close, frame_done;

    // lr_seen gates the first sample after reset so it cannot fake a slot boundary.
    assign boundary = sclk_rise && lr_seen_q && (lrclk_s != lr_prev_q);
    assign msb_bit  = {sdata_s, {(SAMPLE_BITS-1){1'b0}}};

    always_comb begin
        state_d    = state_q;
        lr_prev_d  = lr_prev_q;
        lr_seen_d  = lr_seen_q;
        bit_cnt_d  = bit_cnt_q;
        word_d     = word_q;
        left_d     = left_q;
        left_ok_d  = left_ok_q;
        word_close = 1'b0;
        frame_done = 1'b0;

        // Word including the bit sampled on this edge; bits past SAMPLE_BITS are dropped.
        word_ins = word_q;
        if (bit_cnt_q != CntMax) word_ins = word_q | (msb_bit >> bit_cnt_q);

        if (sclk_rise) begin
            lr_prev_d = lrclk_s;
            lr_seen_d = 1'b1;
        end

        unique case (state_q)
            StWaitSync: begin
                word_d    = '0;
                bit_cnt_d = '0;
                left_ok_d = 1'b0;
                if (enable && boundary) state_d = StCapture;
            end
            StCapture: begin
                if (!enable) begin
                    state_d   = StWaitSync;
                    word_d    = '0;
                    bit_cnt_d = '0;
                    left_ok_d = 1'b0;
                end else if (boundary) begin
                    word_close = 1'b1;
                    word_d     = '0;
                    bit_cnt_d  = '0;
                    if (lr_prev_q == LEFT) begin
                        left_d    = word_ins;
                        left_ok_d = 1'b1;
                    end else begin
                        frame_done = left_ok_q;
                        left_ok_d  = 1'b0;
                    end
                end else if (sclk_rise) begin
                    word_d = word_ins;
                    if (bit_cnt_q != CntMax) bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = StWaitSync;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_clr ? 1'b0 : ovf_q;
        if (valid_q && out_if.sample_ready) valid_d = 1'b0;
        if (frame_done) begin
            if (valid_q && !out_if.sample_ready) begin
                ovf_d = 1'b1;
            end else begin
                data_d  = {left_q, word_ins};
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StWaitSync;
            lr_prev_q <= 1'b0;
            lr_seen_q <= 1'b0;
            bit_cnt_q <= '0;
            word_q    <= '0;
            left_q    <= '0;
            left_ok_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lr_prev_q <= lr_prev_d;
            lr_seen_q <= lr_seen_d;
            bit_cnt_q <= bit_cnt_d;
            word_q    <= word_d;
            left_q    <= left_d;
            left_ok_q <= left_ok_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_if.sample_data  = data_q;
    assign out_if.sample_valid = valid_q;
    assign overflow            = ovf_q;

`ifdef I2S_RX_PEAK_EN
    logic [SAMPLE_BITS:0]   word_sx, word_mag;
    logic [SAMPLE_BITS-1:0] peak_l_q, peak_l_d, peak_r_q, peak_r_d;

    always_comb begin
        // One extra bit so the most negative word has a representable magnitude.
        word_sx  = {word_ins[SAMPLE_BITS-1], word_ins};
        word_mag = word_sx[SAMPLE_BITS] ? (~word_sx + 1'b1) : word_sx;
        peak_l_d = peak_clr ? '0 : peak_l_q;
        peak_r_d = peak_clr ? '0 : peak_r_q;
        if (word_close) begin
            if (lr_prev_q == LEFT) begin
                if (peak_clr || (word_mag[SAMPLE_BITS-1:0] > peak_l_q))
                    peak_l_d = word_mag[SAMPLE_BITS-1:0];
            end else begin
                if (peak_clr || (word_mag[SAMPLE_BITS-1:0] > peak_r_q))
                    peak_r_d = word_mag[SAMPLE_BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_l_q <= '0;
            peak_r_q <= '0;
        end else begin
            peak_l_q <= peak_l_d;
            peak_r_q <= peak_r_d;
        end
    end

    assign peak_l = peak_l_q;
    assign peak_r = peak_r_q;
`endif
endmodule
